// File: rtl/iomem_scheduler_pkg.sv
// Shared types and defaults for the iomem round-robin scheduler.
package iomem_scheduler_pkg;

  // Scheduler FSM: wait for a request, present it to memory, wait for the reply.
  typedef enum logic [1:0] {
    ISCHED_IDLE  = 2'd0,
    ISCHED_ISSUE = 2'd1,
    ISCHED_WAIT  = 2'd2
  } iomem_sched_state_e;

  // Default watchdog limit in cycles (only used when the watchdog is built in).
  localparam int ISCHED_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/iomem_scheduler_rr_arbiter.sv
// Combinational round-robin priority encoder: the search starts one past the
// previous winner and wraps, so every requester gets a turn.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_gnt_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  int cand;

  // Pick the first requester after last_gnt_i, wrapping modulo N.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_gnt_i) + k) % N;
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/iomem_scheduler.sv
// Round-robin scheduler sharing one iomem port between NUM_REQ requesters,
// with exactly one memory transaction outstanding at a time.
// Optional watchdog: define ISCHED_TIMEOUT_EN to turn a hung memory access
// into an error response after TIMEOUT_CYC cycles.
module iomem_scheduler
  import iomem_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = ISCHED_TIMEOUT_CYC
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wstrb_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [DATA_W-1:0]             resp_data_o,
  output logic                          resp_err_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_wstrb_o,
  input  logic                          mem_resp_valid_i,
  input  logic [DATA_W-1:0]             mem_resp_data_i
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;

  iomem_sched_state_e   state_q;
  logic [IDX_W-1:0]     last_gnt_q;
  logic [IDX_W-1:0]     owner_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [STRB_W-1:0]    mem_wstrb_q;
  logic                 mem_req_valid_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [DATA_W-1:0]    resp_data_q;
  logic                 resp_err_q;

  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 accept;
  logic                 tmo_hit;
  logic [NUM_REQ-1:0]   owner_onehot;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i       (req_valid_i),
    .last_gnt_i  (last_gnt_q),
    .gnt_o       (gnt_onehot),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_any)
  );

  // Ready is only offered while idle; gating with rst_ni keeps it low during reset.
  assign req_ready_o  = (state_q == ISCHED_IDLE && rst_ni) ? gnt_onehot : '0;
  assign accept       = (state_q == ISCHED_IDLE) && gnt_any;
  assign owner_onehot = NUM_REQ'(1) << owner_q;

`ifdef ISCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q != ISCHED_IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog: restart when a request is accepted, then count every busy cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ISCHED_IDLE) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Main FSM: latch the granted request, hand it to memory, return the reply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ISCHED_IDLE;
      last_gnt_q      <= IDX_W'(NUM_REQ - 1);
      owner_q         <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      mem_req_valid_q <= 1'b0;
      resp_valid_q    <= '0;
      resp_data_q     <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      unique case (state_q)
        ISCHED_IDLE: begin
          if (gnt_any) begin
            mem_addr_q      <= req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
            mem_wdata_q     <= req_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
            mem_wstrb_q     <= req_wstrb_i[int'(gnt_idx)*STRB_W +: STRB_W];
            owner_q         <= gnt_idx;
            last_gnt_q      <= gnt_idx;
            mem_req_valid_q <= 1'b1;
            state_q         <= ISCHED_ISSUE;
          end
        end
        ISCHED_ISSUE: begin
          if (tmo_hit) begin
            resp_valid_q    <= owner_onehot;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            state_q         <= ISCHED_IDLE;
          end else if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= ISCHED_WAIT;
          end
        end
        ISCHED_WAIT: begin
          if (mem_resp_valid_i) begin
            resp_valid_q <= owner_onehot;
            resp_data_q  <= mem_resp_data_i;
            resp_err_q   <= 1'b0;
            state_q      <= ISCHED_IDLE;
          end else if (tmo_hit) begin
            resp_valid_q <= owner_onehot;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= ISCHED_IDLE;
          end
        end
        default: begin
          mem_req_valid_q <= 1'b0;
          state_q         <= ISCHED_IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign mem_wstrb_o     = mem_wstrb_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign resp_err_o      = resp_err_q;

endmodule

// File: tb/tb_iomem_scheduler.sv
// Testbench for iomem_scheduler: directed requests, a simple memory model and
// a response scoreboard. Define ISCHED_TIMEOUT_EN to include the watchdog case.
module tb_iomem_scheduler;

   localparam int NR = 3;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int SW = DW / 8;

   typedef struct packed {
      logic [NR-1:0] owner;
      logic [DW-1:0] data;
      logic          err;
   } expResp_t;

   logic              clock;
   logic              rstN;
   logic [NR-1:0]     reqValid;
   logic [NR-1:0]     reqReady;
   logic [NR*AW-1:0]  reqAddr;
   logic [NR*DW-1:0]  reqWdata;
   logic [NR*SW-1:0]  reqWstrb;
   logic [NR-1:0]     respValid;
   logic [DW-1:0]     respData;
   logic              respErr;
   logic              memReqValid;
   logic              memReqReady;
   logic [AW-1:0]     memAddr;
   logic [DW-1:0]     memWdata;
   logic [SW-1:0]     memWstrb;
   logic              memRespValid;
   logic [DW-1:0]     memRespData;

   expResp_t expQ[$];
   int checks   = 0;
   int failures = 0;
   bit busy     = 0;

   int            readyDelay = 0;
   int            respDelay  = 1;
   bit            respond    = 1;
   logic [DW-1:0] modelData  = '0;

   iomem_scheduler #(
      .NUM_REQ     (NR),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_i            (clock),
      .rst_ni           (rstN),
      .req_valid_i      (reqValid),
      .req_ready_o      (reqReady),
      .req_addr_i       (reqAddr),
      .req_wdata_i      (reqWdata),
      .req_wstrb_i      (reqWstrb),
      .resp_valid_o     (respValid),
      .resp_data_o      (respData),
      .resp_err_o       (respErr),
      .mem_req_valid_o  (memReqValid),
      .mem_req_ready_i  (memReqReady),
      .mem_addr_o       (memAddr),
      .mem_wdata_o      (memWdata),
      .mem_wstrb_o      (memWstrb),
      .mem_resp_valid_i (memRespValid),
      .mem_resp_data_i  (memRespData)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: got running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_reqReady"},    DW'(reqReady),    '0);
      checkOutput({tag, "_respValid"},   DW'(respValid),   '0);
      checkOutput({tag, "_respData"},    respData,         '0);
      checkOutput({tag, "_respErr"},     DW'(respErr),     '0);
      checkOutput({tag, "_memReqValid"}, DW'(memReqValid), '0);
      checkOutput({tag, "_memAddr"},     DW'(memAddr),     '0);
      checkOutput({tag, "_memWdata"},    memWdata,         '0);
      checkOutput({tag, "_memWstrb"},    DW'(memWstrb),    '0);
   endtask

   // Raise one request, wait (bounded) for its grant, return #1 after the handshake edge.
   task automatic applyStimulus(input int idx, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
      int n = 0;
      @(negedge clock);
      reqAddr[idx*AW +: AW]  = addr;
      reqWdata[idx*DW +: DW] = wdata;
      reqWstrb[idx*SW +: SW] = wstrb;
      reqValid[idx]          = 1'b1;
      #1;
      while (!reqReady[idx] && n < 200) begin
         @(negedge clock);
         #1;
         n++;
      end
      checkOutput("grantWait", DW'(reqReady[idx]), DW'(1));
      @(posedge clock);
      #1;
      reqValid[idx] = 1'b0;
   endtask

   task automatic pushExp(input logic [NR-1:0] owner, input logic [DW-1:0] data,
                          input logic err);
      expResp_t e;
      e.owner = owner;
      e.data  = data;
      e.err   = err;
      expQ.push_back(e);
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(posedge clock);
         n++;
      end
      checkOutput("drain", DW'(expQ.size()), '0);
      repeat (2) @(posedge clock);
   endtask

   // Memory model: accept after readyDelay stalled cycles, reply respDelay cycles after acceptance.
   initial begin
      memReqReady  = 1'b0;
      memRespValid = 1'b0;
      memRespData  = '0;
      forever begin
         @(negedge clock);
         memReqReady  = 1'b0;
         memRespValid = 1'b0;
         if (rstN && memReqValid) begin
            repeat (readyDelay) @(negedge clock);
            memReqReady = 1'b1;
            @(negedge clock);
            memReqReady = 1'b0;
            repeat (respDelay - 1) @(negedge clock);
            if (respond) begin
               memRespValid = 1'b1;
               memRespData  = modelData;
            end
         end
      end
   end

   // Scoreboard: every response pulse must match the oldest expected entry.
   initial begin
      expResp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (respValid != '0) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedResp", DW'(respValid), '0);
            end else begin
               e = expQ.pop_front();
               checkOutput("respOwner", DW'(respValid), DW'(e.owner));
               checkOutput("respData", respData, e.data);
               checkOutput("respErr", DW'(respErr), DW'(e.err));
            end
         end
      end
   end

   // Grant monitor: ready is one-hot and never offered while a transaction is in flight.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (!rstN || respValid != '0) busy = 0;
         if (reqReady != '0) begin
            checkOutput("readyOneHot", DW'($countones(reqReady)), DW'(1));
            checkOutput("grantWhileBusy", DW'(busy), '0);
            if ((reqReady & reqValid) != '0) busy = 1;
         end
      end
   end

   initial begin
      int n;
      bit sawResp;
      logic [NR-1:0] grantOrder [4];
      grantOrder[0] = 3'b001;
      grantOrder[1] = 3'b010;
      grantOrder[2] = 3'b100;
      grantOrder[3] = 3'b001;

      // Reset with all requesters already asking.
      rstN     = 1'b0;
      reqValid = '1;
      reqWdata = '0;
      reqWstrb = '0;
      for (int k = 0; k < NR; k++) reqAddr[k*AW +: AW] = 32'h4000_0000 + 32'(k * 'h40);
      repeat (3) @(posedge clock);
      #1;
      checkAllZero("reset");
      @(negedge clock);
      rstN = 1'b1;

      // Contention: grants must rotate 0,1,2,0.
      $display("[TB] contention");
      readyDelay = 0;
      respDelay  = 1;
      modelData  = {8{16'h1111}};
      for (int g = 0; g < 4; g++) pushExp(grantOrder[g], modelData, 1'b0);
      for (int g = 0; g < 4; g++) begin
         n = 0;
         #1;
         while (reqReady == '0 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
         end
         checkOutput("grantOrder", DW'(reqReady), DW'(grantOrder[g]));
         @(posedge clock);
         #1;
      end
      reqValid = '0;
      waitDrain();

      // Single read from requester 0.
      $display("[TB] single read");
      respDelay = 2;
      modelData = {16{8'hA5}};
      pushExp(3'b001, {16{8'hA5}}, 1'b0);
      applyStimulus(0, 32'h8000_0040, '0, '0);
      checkOutput("readValid", DW'(memReqValid), DW'(1));
      checkOutput("readAddr", DW'(memAddr), DW'(32'h8000_0040));
      checkOutput("readStrb", DW'(memWstrb), '0);
      waitDrain();

      // Backpressure: memory stalls 5 cycles, fields must hold.
      $display("[TB] backpressure");
      readyDelay = 5;
      respDelay  = 1;
      modelData  = {4{32'hDEAD_BEEF}};
      pushExp(3'b100, {4{32'hDEAD_BEEF}}, 1'b0);
      applyStimulus(2, 32'h1000_0080, '0, '0);
      for (int c = 1; c <= 6; c++) begin
         checkOutput("bpValid", DW'(memReqValid), DW'(1));
         checkOutput("bpAddr", DW'(memAddr), DW'(32'h1000_0080));
         @(posedge clock);
         #1;
      end
      checkOutput("bpAccepted", DW'(memReqValid), '0);
      waitDrain();

      // Write from requester 1.
      $display("[TB] write");
      readyDelay = 0;
      respDelay  = 1;
      modelData  = {4{32'h0BAD_F00D}};
      pushExp(3'b010, {4{32'h0BAD_F00D}}, 1'b0);
      applyStimulus(1, 32'h2000_0000, 128'h1234, 16'h000F);
      checkOutput("wrValid", DW'(memReqValid), DW'(1));
      checkOutput("wrStrb", DW'(memWstrb), DW'(16'h000F));
      checkOutput("wrData", memWdata, 128'h1234);
      checkOutput("wrAddr", DW'(memAddr), DW'(32'h2000_0000));
      waitDrain();

      // Reset while waiting for memory: no response may appear afterwards.
      $display("[TB] reset mid-wait");
      respDelay = 4;
      modelData = {4{32'hCAFE_0001}};
      applyStimulus(0, 32'h3000_0000, '0, '0);
      @(posedge clock);
      #1;
      checkOutput("inWait", DW'(memReqValid), '0);
      @(negedge clock);
      rstN = 1'b0;
      #1;
      checkAllZero("midReset");
      @(negedge clock);
      rstN    = 1'b1;
      sawResp = 0;
      repeat (10) begin
         @(posedge clock);
         #1;
         if (respValid != '0) sawResp = 1;
      end
      checkOutput("noRespAfterReset", DW'(sawResp), '0);

`ifdef ISCHED_TIMEOUT_EN
      // Watchdog: memory answers too late, error response first, late reply ignored.
      $display("[TB] timeout");
      readyDelay = 0;
      respDelay  = 20;
      modelData  = {4{32'h5555_AAAA}};
      pushExp(3'b100, '0, 1'b1);
      applyStimulus(2, 32'h5000_0000, '0, '0);
      waitDrain();
      sawResp = 0;
      repeat (15) begin
         @(posedge clock);
         #1;
         if (respValid != '0) sawResp = 1;
      end
      checkOutput("lateRespIgnored", DW'(sawResp), '0);
`endif

      repeat (3) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
